// File: rtl/sms_region_guard.sv
// AHB address-phase window checker: combinational deny flags, sticky first-fault capture, level interrupt.
// Build option SMS_GUARD_FAULT_CNT_EN adds a saturating denied-transfer counter readable at 0x0C.
module sms_region_guard #(
  parameter int NUM_REGIONS = 4,
  parameter int GRAN_LOG2   = 12
) (
  input  logic        mem_hclk,
  input  logic        mem_hrst,
  input  logic [31:0] mem_haddr,
  input  logic        mem_hsel,
  input  logic [1:0]  mem_htrans,
  input  logic        mem_hwrite,
  input  logic [2:0]  mem_hsize,
  input  logic [3:0]  mem_hprot,
  input  logic        mem_hready,
  output logic        region_rd_deny_flag,
  output logic        region_wr_deny_flag,
  input  logic        cfg_sel,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        guard_irq
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] base_q  [NUM_REGIONS];
  logic [31:0] base_d  [NUM_REGIONS];
  logic [31:0] limit_q [NUM_REGIONS];
  logic [31:0] limit_d [NUM_REGIONS];
  // attr packed as {lock, priv_only, wr, rd, en}
  logic [4:0]  attr_q  [NUM_REGIONS];
  logic [4:0]  attr_d  [NUM_REGIONS];

  logic        valid_q, valid_d, ovf_q, ovf_d, fwrite_q, fwrite_d;
  logic [2:0]  fsize_q, fsize_d;
  logic [3:0]  fprot_q, fprot_d;
  logic [31:0] faddr_q, faddr_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic [4:0]  hit_attr;
  logic        rd_ok, wr_ok, rd_deny, wr_deny, denied;
  logic        wr_stb, rd_stb;
  logic [5:0]  cfg_word;
  logic [1:0]  w1c;
  logic [31:0] fcnt_rd;
  logic        unused_ok;

  assign unused_ok = ^{mem_htrans[0], cfg_addr[1:0]};

  // Scan from the top so the lowest matching index is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_attr = '0;
    for (int n = NUM_REGIONS - 1; n >= 0; n--) begin
      if (attr_q[n][0] &&
          mem_haddr[31:GRAN_LOG2] >= base_q[n][31:GRAN_LOG2] &&
          mem_haddr[31:GRAN_LOG2] <= limit_q[n][31:GRAN_LOG2]) begin
        hit      = 1'b1;
        hit_attr = attr_q[n];
      end
    end
  end

  assign rd_ok   = hit ? (hit_attr[1] & (~hit_attr[3] | mem_hprot[1])) : ctrl_q[1];
  assign wr_ok   = hit ? (hit_attr[2] & (~hit_attr[3] | mem_hprot[1])) : ctrl_q[1];
  assign rd_deny = ctrl_q[0] & ~rd_ok;
  assign wr_deny = ctrl_q[0] & ~wr_ok;
  assign denied  = mem_hsel & mem_hready & mem_htrans[1] & (mem_hwrite ? wr_deny : rd_deny);

  assign region_rd_deny_flag = rd_deny;
  assign region_wr_deny_flag = wr_deny;

  assign cfg_word = cfg_addr[7:2];
  assign wr_stb   = cfg_sel & cfg_wr;
  assign rd_stb   = cfg_sel & ~cfg_wr;
  assign w1c      = (wr_stb && cfg_word == 6'd1) ? cfg_wdata[1:0] : 2'b00;

  always_comb begin
    ctrl_d  = ctrl_q;
    base_d  = base_q;
    limit_d = limit_q;
    attr_d  = attr_q;
    if (wr_stb && cfg_word == 6'd0) ctrl_d = cfg_wdata[2:0];
    for (int n = 0; n < NUM_REGIONS; n++) begin
      if (wr_stb && !attr_q[n][4] && cfg_addr[7:4] == 4'(n + 1)) begin
        case (cfg_addr[3:2])
          2'd0:    base_d[n]  = cfg_wdata;
          2'd1:    limit_d[n] = cfg_wdata;
          2'd2:    attr_d[n]  = {cfg_wdata[7], cfg_wdata[3:0]};
          default: ;
        endcase
      end
    end
  end

  // A same-cycle W1C is applied first, so a new fault reloads cleanly over it.
  always_comb begin
    valid_d  = valid_q & ~w1c[0];
    ovf_d    = ovf_q & ~w1c[1];
    faddr_d  = faddr_q;
    fwrite_d = fwrite_q;
    fsize_d  = fsize_q;
    fprot_d  = fprot_q;
    if (denied) begin
      if (!valid_d) begin
        valid_d  = 1'b1;
        faddr_d  = mem_haddr;
        fwrite_d = mem_hwrite;
        fsize_d  = mem_hsize;
        fprot_d  = mem_hprot;
      end else begin
        ovf_d = 1'b1;
      end
    end
    irq_d = ctrl_d[2] & valid_d;
  end

`ifdef SMS_GUARD_FAULT_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (wr_stb && cfg_word == 6'd3)      fcnt_d = '0;
    else if (denied && fcnt_q != 8'hFF)  fcnt_d = fcnt_q + 8'd1;
  end

  always_ff @(posedge mem_hclk or posedge mem_hrst) begin
    if (mem_hrst) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign fcnt_rd = {24'd0, fcnt_q};
`else
  assign fcnt_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    if (rd_stb) begin
      case (cfg_word)
        6'd0: rdata_d = {29'd0, ctrl_q};
        6'd1: rdata_d = {20'd0, fprot_q, 1'b0, fsize_q, 1'b0, fwrite_q, ovf_q, valid_q};
        6'd2: rdata_d = faddr_q;
        6'd3: rdata_d = fcnt_rd;
        default: begin
          for (int n = 0; n < NUM_REGIONS; n++) begin
            if (cfg_addr[7:4] == 4'(n + 1)) begin
              case (cfg_addr[3:2])
                2'd0:    rdata_d = base_q[n];
                2'd1:    rdata_d = limit_q[n];
                2'd2:    rdata_d = {24'd0, attr_q[n][4], 3'd0, attr_q[n][3:0]};
                default: rdata_d = '0;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge mem_hclk or posedge mem_hrst) begin
    if (mem_hrst) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      fwrite_q <= 1'b0;
      fsize_q  <= '0;
      fprot_q  <= '0;
      faddr_q  <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      for (int n = 0; n < NUM_REGIONS; n++) begin
        base_q[n]  <= '0;
        limit_q[n] <= '0;
        attr_q[n]  <= '0;
      end
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      fwrite_q <= fwrite_d;
      fsize_q  <= fsize_d;
      fprot_q  <= fprot_d;
      faddr_q  <= faddr_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      for (int n = 0; n < NUM_REGIONS; n++) begin
        base_q[n]  <= base_d[n];
        limit_q[n] <= limit_d[n];
        attr_q[n]  <= attr_d[n];
      end
    end
  end

  assign cfg_rdata = rdata_q;
  assign guard_irq = irq_q;

endmodule
